// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - data-memory request/response bus between the load/store unit and memory
interface lsu_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: one outstanding data-memory access with alignment, funct3 and timeout checks
module lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] load_data,
  lsu_if.master       mem
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  logic        busy_q, done_q, err_q;
  logic [31:0] load_data_q;
  logic        req_q, we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic [15:0] cnt_q;
  logic        is_store_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;

  logic        legal_d;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] ext_d;
  logic [7:0]  byte_d;
  logic [15:0] half_d;

  always_comb begin
    legal_d = 1'b0;
    if (is_store) begin
      case (funct3)
        3'b000:  legal_d = 1'b1;
        3'b001:  legal_d = ~addr[0];
        3'b010:  legal_d = (addr[1:0] == 2'b00);
        default: legal_d = 1'b0;
      endcase
    end else begin
      case (funct3)
        3'b000, 3'b100: legal_d = 1'b1;
        3'b001, 3'b101: legal_d = ~addr[0];
        3'b010:         legal_d = (addr[1:0] == 2'b00);
        default:        legal_d = 1'b0;
      endcase
    end
  end

  // Lane replication lets memory pick bytes by mem_be alone, without a shifter.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = store_data;
    case (funct3[1:0])
      2'b00: begin
        be_d    = 4'b0001 << addr[1:0];
        wdata_d = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_d    = 4'b0011 << addr[1:0];
        wdata_d = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_d = mem.mem_rdata[{off_q, 3'b000} +: 8];
    half_d = mem.mem_rdata[{off_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  ext_d = {{24{byte_d[7]}}, byte_d};
      3'b100:  ext_d = {24'd0, byte_d};
      3'b001:  ext_d = {{16{half_d[15]}}, half_d};
      3'b101:  ext_d = {16'd0, half_d};
      default: ext_d = mem.mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      load_data_q <= 32'd0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      be_q        <= 4'd0;
      cnt_q       <= 16'd0;
      is_store_q  <= 1'b0;
      funct3_q    <= 3'd0;
      off_q       <= 2'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            is_store_q <= is_store;
            funct3_q   <= funct3;
            off_q      <= addr[1:0];
            busy_q     <= 1'b1;
            if (legal_d) begin
              state_q <= ACCESS;
              req_q   <= 1'b1;
              we_q    <= is_store;
              addr_q  <= {addr[31:2], 2'b00};
              be_q    <= be_d;
              wdata_q <= wdata_d;
              cnt_q   <= 16'd0;
            end else begin
              state_q     <= RESP;
              done_q      <= 1'b1;
              err_q       <= 1'b1;
              load_data_q <= 32'd0;
            end
          end
        end
        ACCESS: begin
          // An ack in the limit cycle is checked first so it wins over the timeout.
          if (mem.mem_ack) begin
            state_q     <= RESP;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            be_q        <= 4'd0;
            done_q      <= 1'b1;
            err_q       <= 1'b0;
            load_data_q <= is_store_q ? 32'd0 : ext_d;
          end else if (cnt_q == LIMIT) begin
            state_q     <= RESP;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            be_q        <= 4'd0;
            done_q      <= 1'b1;
            err_q       <= 1'b1;
            load_data_q <= 32'd0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign load_data     = load_data_q;
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_be    = be_q;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - randomized self-checking bench for lsu against an arithmetic reference model
module tb_lsu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] store_data = 32'd0;
  logic        busy, done, err;
  logic [31:0] load_data;

  int n_checks = 0;
  int n_fail = 0;

  lsu_if bus ();

  lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .store_data(store_data), .busy(busy), .done(done), .err(err),
    .load_data(load_data), .mem(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          ok;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] ld;
  } exp_t;

  // Reference: access size in bytes, natural alignment, replicate/extract by arithmetic.
  function automatic exp_t model(bit st, bit [2:0] f3, bit [31:0] a, bit [31:0] sd, bit [31:0] rd);
    exp_t e;
    int size;
    int o;
    bit [31:0] v, mask;
    o = int'(a % 4);
    case (f3[1:0])
      2'd0: size = 1;
      2'd1: size = 2;
      2'd2: size = 4;
      default: size = 0;
    endcase
    if (st) e.ok = (f3 <= 3'd2);
    else    e.ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (size == 0) e.ok = 0;
    else if (o % size != 0) e.ok = 0;
    e.be = (size == 0) ? 4'd0 : 4'(((1 << size) - 1) << o);
    for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = (size == 0) ? 8'd0 : sd[8*(i % size) +: 8];
    e.ld = 32'd0;
    if (!st && e.ok) begin
      v = rd >> (8 * o);
      if (size < 4) begin
        mask = (32'd1 << (8 * size)) - 32'd1;
        v = v & mask;
        if (!f3[2] && v[8*size-1]) v = v | ~mask;
      end
      e.ld = v;
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_access(input bit st, input bit [2:0] f3, input bit [31:0] a,
                           input bit [31:0] sd, input bit [31:0] rd, input int lat, input string nm);
    exp_t e;
    logic [31:0] prev_ld;
    e = model(st, f3, a, sd, rd);
    is_store = st; funct3 = f3; addr = a; store_data = sd; start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL %s busy: got %b want 1", nm, busy); end
    if (!e.ok) begin
      n_checks++;
      if ({done, err, bus.mem_req, load_data} !== {1'b1, 1'b1, 1'b0, 32'd0}) begin
        n_fail++;
        $display("FAIL %s illegal: got done=%b err=%b req=%b ld=%h want 1 1 0 0", nm, done, err, bus.mem_req, load_data);
      end
    end else begin
      n_checks++;
      if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata} !== {1'b1, st, a & ~32'd3, e.be, e.wdata}) begin
        n_fail++;
        $display("FAIL %s request: got req=%b we=%b addr=%h be=%b wdata=%h want 1 %b %h %b %h",
                 nm, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata, st, a & ~32'd3, e.be, e.wdata);
      end
      for (int i = 0; i < lat; i++) begin
        step();
        n_checks++;
        if ({bus.mem_req, bus.mem_addr, bus.mem_be, done} !== {1'b1, a & ~32'd3, e.be, 1'b0}) begin
          n_fail++;
          $display("FAIL %s hold%0d: got req=%b addr=%h be=%b done=%b", nm, i, bus.mem_req, bus.mem_addr, bus.mem_be, done);
        end
      end
      bus.mem_ack = 1'b1; bus.mem_rdata = rd;
      step();
      bus.mem_ack = 1'b0; bus.mem_rdata = $urandom;
      n_checks++;
      if ({done, err, bus.mem_req, bus.mem_we, bus.mem_be, load_data} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, e.ld}) begin
        n_fail++;
        $display("FAIL %s complete: got done=%b err=%b req=%b we=%b be=%b ld=%h want ld=%h",
                 nm, done, err, bus.mem_req, bus.mem_we, bus.mem_be, load_data, e.ld);
      end
    end
    prev_ld = e.ok ? e.ld : 32'd0;
    step();
    n_checks++;
    if ({done, busy, load_data} !== {1'b0, 1'b0, prev_ld}) begin
      n_fail++;
      $display("FAIL %s after: got done=%b busy=%b ld=%h want 0 0 %h", nm, done, busy, load_data, prev_ld);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'd0;
    step();
    n_checks++;
    if ({busy, done, err, load_data, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be} !== 104'd0) begin
      n_fail++;
      $display("FAIL reset: outputs not zero busy=%b done=%b err=%b ld=%h req=%b", busy, done, err, load_data, bus.mem_req);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_directed();
    do_access(0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, "lw");
    do_access(0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 0, "lb");
    do_access(0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 1, "lbu");
    do_access(0, 3'b001, 32'h102, 32'h0, 32'h80FF1234, 0, "lh");
    do_access(1, 3'b000, 32'h201, 32'hA5, 32'h12345678, 0, "sb");
    do_access(1, 3'b001, 32'h201, 32'hBEEF, 32'h0, 0, "sh_misaligned");
    do_access(0, 3'b010, 32'h102, 32'h0, 32'h0, 0, "lw_misaligned");
    do_access(1, 3'b011, 32'h200, 32'h0, 32'h0, 0, "store_f3_011");
    do_access(0, 3'b101, 32'h3FE, 32'h0, 32'h9ABC5678, 3, "lhu_ack_limit");
  endtask

  task automatic test_random();
    for (int k = 0; k < 60; k++) begin
      do_access(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom, int'($urandom_range(0, 3)), "random");
    end
  endtask

  task automatic test_timeout();
    int high = 0;
    is_store = 0; funct3 = 3'b010; addr = 32'h400; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 10 && bus.mem_req === 1'b1; i++) begin
      high++;
      step();
    end
    n_checks++;
    if (high != 4) begin n_fail++; $display("FAIL timeout req_cycles: got %0d want 4", high); end
    n_checks++;
    if ({done, err, load_data} !== {1'b1, 1'b1, 32'd0}) begin
      n_fail++;
      $display("FAIL timeout complete: got done=%b err=%b ld=%h want 1 1 0", done, err, load_data);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    is_store = 0; funct3 = 3'b010; addr = 32'h500; start = 1'b1;
    step();
    is_store = 1; funct3 = 3'b000; addr = 32'h604; start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 32'h500}) begin
      n_fail++;
      $display("FAIL ignore_start request: got req=%b we=%b addr=%h want 1 0 00000500", bus.mem_req, bus.mem_we, bus.mem_addr);
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h11223344;
    step();
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (done === 1'b1) dones++;
      step();
    end
    n_checks++;
    if (dones != 1) begin n_fail++; $display("FAIL ignore_start dones: got %0d want 1", dones); end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    is_store = 1; funct3 = 3'b010; addr = 32'h700; store_data = 32'hCAFEF00D; start = 1'b1;
    step();
    start = 1'b0;
    step();
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.mem_req, busy, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_mid: got req=%b busy=%b done=%b want 0 0 0", bus.mem_req, busy, done);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (done === 1'b1) dones++;
      step();
    end
    n_checks++;
    if (dones != 0) begin n_fail++; $display("FAIL reset_mid dones: got %0d want 0", dones); end
    do_access(0, 3'b000, 32'h701, 32'h0, 32'h0000_7F00, 1, "after_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
